rf_cmd_ctrl: RTL and testbench

RF_CMD_CTRL -- requirements
Module: rf_cmd_ctrl

---
 rtl/rf_cmd_ctrl.sv | 131 +++++++++++++
 tb/tb_rf_cmd_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rf_cmd_ctrl.sv
// rf_cmd_ctrl: sequences WRITE/READ/COPY/SWAP commands onto an external register file
module rf_cmd_ctrl #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_a,
  input  logic [AW-1:0] cmd_b,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_a,
  output logic [DW-1:0] rsp_b,
  output logic [7:0]    done_cnt,
  output logic [AW-1:0] RA,
  output logic [AW-1:0] RB,
  output logic          RE,
  output logic [AW-1:0] WR,
  output logic [DW-1:0] WRD,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B
);
  typedef enum logic [2:0] {IDLE, RD, WR1, WR2, RESP} state_t;
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;
  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] data_q, data_d, cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic [7:0]    done_q, done_d;
  logic          cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, re_q, re_d;
  logic [AW-1:0] ra_q, ra_d, rb_q, rb_d, wr_q, wr_d;
  logic [DW-1:0] wrd_q, wrd_d;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_a     = cap_a_q;
  assign rsp_b     = cap_b_q;
  assign done_cnt  = done_q;
  assign RA        = ra_q;
  assign RB        = rb_q;
  assign RE        = re_q;
  assign WR        = wr_q;
  assign WRD       = wrd_q;
  // Sequencing: latch on accept, capture read data leaving RD, count on response handshake
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    cap_a_d = cap_a_q;
    cap_b_d = cap_b_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        op_d    = cmd_op;
        a_d     = cmd_a;
        b_d     = cmd_b;
        data_d  = cmd_data;
        state_d = RD;
      end
      RD: begin
        cap_a_d = A;
        cap_b_d = B;
        state_d = (op_q == OP_READ) ? RESP : WR1;
      end
      WR1: state_d = (op_q == OP_SWAP) ? WR2 : RESP;
      WR2: state_d = RESP;
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        done_d  = done_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Port values for the state being entered, so every output comes straight from a flop
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    ra_d        = (state_d == RD) ? a_d : '0;
    rb_d        = (state_d == RD) ? b_d : '0;
    re_d        = (state_d == WR1) || (state_d == WR2);
    wr_d        = (state_d == WR2) ? b_d :
                  (state_d == WR1) ? ((op_d == OP_COPY) ? b_d : a_d) : '0;
    wrd_d       = (state_d == WR2) ? cap_a_d :
                  (state_d == WR1) ? ((op_d == OP_WRITE) ? data_d :
                                      (op_d == OP_COPY)  ? cap_a_d : cap_b_d) : '0;
  end
  // State and output registers; reset aborts any command in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      done_q      <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      ra_q        <= '0;
      rb_q        <= '0;
      re_q        <= 1'b0;
      wr_q        <= '0;
      wrd_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      re_q        <= re_d;
      wr_q        <= wr_d;
      wrd_q       <= wrd_d;
    end
  end
endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// tb_rf_cmd_ctrl: directed checks of rf_cmd_ctrl against a 4x4 register file model
module tb_rf_cmd_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0, cmd_a = '0, cmd_b = '0;
  logic [3:0] cmd_data = '0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [3:0] rsp_a, rsp_b;
  logic [7:0] done_cnt;
  logic [1:0] RA, RB, WR;
  logic       RE;
  logic [3:0] WRD, A, B;
  logic [3:0] mem [4];
  int         total = 0, bad = 0, lat, nre;
  logic [1:0] first_wr;
  logic [3:0] first_wrd, hold_a, hold_b;
  logic [7:0] exp_done = '0;

  rf_cmd_ctrl #(.DW(4), .AW(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .done_cnt(done_cnt), .RA(RA), .RB(RB), .RE(RE), .WR(WR), .WRD(WRD), .A(A), .B(B)
  );

  always #5 clk = ~clk;
  assign A = mem[RA];
  assign B = mem[RB];
  always @(posedge clk) if (RE) mem[WR] <= WRD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one command at a negedge and wait (bounded) for rsp_valid, recording the writes seen
  task automatic issue(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b, input logic [3:0] d);
    chk("ready_in_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_data = d;
    @(posedge clk); @(negedge clk);
    cmd_op = 2'b00; cmd_a = 2'd3; cmd_b = 2'd3; cmd_data = 4'hF;
    lat = 1; nre = 0; first_wr = '0; first_wrd = '0;
    while (!rsp_valid && lat < 20) begin
      chk("busy_not_ready", cmd_ready, 0);
      if (RE) begin
        if (nre == 0) begin first_wr = WR; first_wrd = WRD; end
        nre++;
      end
      @(posedge clk); @(negedge clk);
      lat++;
    end
    cmd_valid = 1'b0;
    chk("rsp_valid_seen", rsp_valid, 1);
  endtask

  task automatic respond();
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    exp_done = exp_done + 8'd1;
    chk("done_cnt", done_cnt, exp_done);
    chk("rsp_dropped", rsp_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_re", RE, 0);
    chk("rst_ra_rb", {RA, RB}, 0);
    chk("rst_wr_wrd", {WR, WRD}, 0);
    chk("rst_rsp", {rsp_valid, rsp_a, rsp_b}, 0);
    chk("rst_done", done_cnt, 0);
    cmd_valid = 1'b0;
    reset = 1'b1;
    #1 chk("ready_before_edge", cmd_ready, 0);
    @(posedge clk); @(negedge clk);
    chk("ready_after_release", cmd_ready, 1);

    issue(2'b00, 2'd2, 2'd0, 4'b1010);
    chk("wr_lat", lat, 3);
    chk("wr_nre", nre, 1);
    chk("wr_wr", first_wr, 2);
    chk("wr_wrd", first_wrd, 4'b1010);
    chk("wr_rsp", {rsp_a, rsp_b}, 8'h00);
    respond();
    chk("wr_mem2", mem[2], 4'b1010);

    issue(2'b01, 2'd2, 2'd0, 4'h0);
    chk("rd_lat", lat, 2);
    chk("rd_nre", nre, 0);
    chk("rd_rsp_a", rsp_a, 4'b1010);
    chk("rd_rsp_b", rsp_b, 4'b0000);
    respond();

    issue(2'b00, 2'd0, 2'd0, 4'b1101); respond();
    issue(2'b00, 2'd1, 2'd0, 4'b0011); respond();
    issue(2'b11, 2'd0, 2'd1, 4'h0);
    chk("swap_lat", lat, 4);
    chk("swap_nre", nre, 2);
    chk("swap_wr1", {first_wr, first_wrd}, {2'd0, 4'b0011});
    chk("swap_rsp_a", rsp_a, 4'b1101);
    chk("swap_rsp_b", rsp_b, 4'b0011);
    respond();
    chk("swap_mem0", mem[0], 4'b0011);
    chk("swap_mem1", mem[1], 4'b1101);

    issue(2'b00, 2'd1, 2'd0, 4'b0011); respond();
    issue(2'b10, 2'd1, 2'd3, 4'h0);
    chk("copy_lat", lat, 3);
    chk("copy_wr1", {first_wr, first_wrd}, {2'd3, 4'b0011});
    chk("copy_rsp", {rsp_a, rsp_b}, {4'b0011, 4'b0000});
    respond();
    chk("copy_mem3", mem[3], 4'b0011);

    issue(2'b10, 2'd2, 2'd2, 4'h0);
    chk("copy_same_nre", nre, 1);
    chk("copy_same_rsp", {rsp_a, rsp_b}, {4'b1010, 4'b1010});
    respond();
    chk("copy_same_mem2", mem[2], 4'b1010);
    issue(2'b11, 2'd2, 2'd2, 4'h0);
    chk("swap_same_nre", nre, 2);
    chk("swap_same_rsp", {rsp_a, rsp_b}, {4'b1010, 4'b1010});
    respond();
    chk("swap_same_mem2", mem[2], 4'b1010);

    issue(2'b01, 2'd0, 2'd1, 4'h0);
    hold_a = rsp_a; hold_b = rsp_b;
    chk("stall_rsp", {hold_a, hold_b}, {4'b0011, 4'b0011});
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk("stall_hold", {rsp_valid, rsp_a, rsp_b}, {1'b1, hold_a, hold_b});
      chk("stall_ctl", {cmd_ready, RE}, 2'b00);
    end
    cmd_valid = 1'b0;
    respond();

    issue(2'b00, 2'd0, 2'd0, 4'b0101); respond();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_a = 2'd0; cmd_b = 2'd1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_in_wr1", {RE, WR, WRD}, {1'b1, 2'd0, 4'b0011});
    reset = 1'b0;
    #1;
    chk("abort_re", RE, 0);
    chk("abort_outs", {RA, RB, WR, WRD}, 0);
    chk("abort_rsp", {rsp_valid, rsp_a, rsp_b}, 0);
    chk("abort_done", done_cnt, 0);
    chk("abort_ready", cmd_ready, 0);
    @(posedge clk); @(negedge clk);
    chk("abort_mem0", mem[0], 4'b0101);
    chk("abort_mem1", mem[1], 4'b0011);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_ready_after", cmd_ready, 1);
    chk("abort_no_rsp", rsp_valid, 0);
    exp_done = '0;

    for (int i = 0; i < 256; i++) begin
      issue(2'b01, 2'(i), 2'(i + 1), 4'h0);
      respond();
    end
    chk("wrap_done", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
